// File: rtl/sram22_pkg.sv
// Shared geometry and transaction types for the sram22 1024x32 macro front-end.
package sram22_pkg;

  localparam int SRAM22_DATA_WIDTH  = 32;
  localparam int SRAM22_ADDR_WIDTH  = 10;
  localparam int SRAM22_WMASK_WIDTH = 1;

  typedef struct packed {
    logic                          we;
    logic [SRAM22_WMASK_WIDTH-1:0] wmask;
    logic [SRAM22_ADDR_WIDTH-1:0]  addr;
    logic [SRAM22_DATA_WIDTH-1:0]  wdata;
  } sram22_req_t;

  typedef struct packed {
    logic [SRAM22_DATA_WIDTH-1:0] rdata;
  } sram22_rsp_t;

endpackage

// File: rtl/sram22_rsp_fifo.sv
// Circular response FIFO with explicit occupancy count; depth need not be a power of two.
module sram22_rsp_fifo
  import sram22_pkg::*;
#(
  parameter int WIDTH = SRAM22_DATA_WIDTH,
  parameter int DEPTH = 3,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_eff;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign pop_eff = pop && !empty;
  // Storage is never reset; the head is masked while empty so no stale word is visible.
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)    wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (pop_eff) rd_ptr_q <= wrap_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  // Upstream credit accounting must make an overflowing push impossible.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop_eff && count_q == CNT_W'(DEPTH)))
        else $error("sram22_rsp_fifo: push into full fifo");
    end
  end

endmodule

// File: rtl/sram22_rv_adapter.sv
// Valid/ready front-end for the sram22 macro: drives macro pins on request fire and
// returns 1-cycle-latency read data through a credit-protected response FIFO.
module sram22_rv_adapter
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = SRAM22_DATA_WIDTH,
  parameter int ADDR_WIDTH  = SRAM22_ADDR_WIDTH,
  parameter int WMASK_WIDTH = SRAM22_WMASK_WIDTH,
  parameter int RESP_DEPTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic             req_fire;
  logic             rd_fire_p0;
  logic             rd_vld_p1;
  logic             rsp_pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credits_used;

  // A read holds a credit from fire until its data lands in the FIFO.
  assign credits_used = {{CNT_W{1'b0}}, rd_vld_p1} + {1'b0, fifo_count};
  assign req_ready    = !rst && (credits_used < (CNT_W + 1)'(RESP_DEPTH));
  assign req_fire     = req_valid && req_ready;
  assign rd_fire_p0   = req_fire && !req_we;

  assign sram_we    = req_fire && req_we;
  assign sram_wmask = (req_we && !rst) ? req_wmask : '0;
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;

  // p0 -> p1: macro returns dout the cycle after the read is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_vld_p1 <= 1'b0;
    else     rd_vld_p1 <= rd_fire_p0;
  end

  assign rsp_valid = !fifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;

  sram22_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld_p1),
    .pop   (rsp_pop),
    .din   (sram_dout),
    .head  (rsp_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram22_rv_adapter.sv
// Directed and randomised checks of sram22_rv_adapter against a behavioural macro and scoreboard.
module tb_sram22_rv_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [0:0]  req_wmask;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        sram_we;
  logic [0:0]  sram_wmask;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic        preload;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram22_rv_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_wmask  (req_wmask),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_we    (sram_we),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Behavioural macro: 1-cycle read latency, X on dout after a write cycle.
  logic [31:0] smem [1024];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) smem[i] <= 32'(i * 3);
    end else begin
      if (sram_we && sram_wmask[0]) smem[sram_addr] <= sram_din;
      sram_dout <= sram_we ? 32'hxxxx_xxxx : smem[sram_addr];
    end
  end

  // Scoreboard state
  logic [31:0] shadow [1024];
  logic [31:0] q[$];
  int          m_cnt;
  bit          m_infl;
  bit          last_fire;
  bit          last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_cnt  = 0;
    m_infl = 0;
  endtask

  task automatic tick();
    bit mready, mfire, mpop;
    #1;
    mready = (32'(m_infl) + 32'(m_cnt)) < 3;
    mfire  = req_valid && mready;
    mpop   = (m_cnt > 0) && rsp_ready;
    last_fire = req_valid && req_ready;
    last_pop  = rsp_valid && rsp_ready;
    chk("req_ready", 32'(req_ready), 32'(mready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_cnt > 0));
    if (m_cnt > 0) chk("rsp_rdata", rsp_rdata, q[0]);
    chk("sram_we", 32'(sram_we), 32'(mfire && req_we));
    if (mpop) begin
      void'(q.pop_front());
      m_cnt--;
    end
    if (m_infl) m_cnt++;
    m_infl = mfire && !req_we;
    if (mfire && req_we && req_wmask[0]) shadow[req_addr] = req_wdata;
    if (mfire && !req_we) q.push_back(shadow[req_addr]);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [9:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_wmask = 1'b1;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    int acc, nresp, ops, cyc, r;
    logic [9:0] a;

    for (int i = 0; i < 1024; i++) shadow[i] = 32'(i * 3);
    model_clear();
    rst = 1'b1;
    preload = 1'b1;
    rsp_ready = 1'b1;
    set_req(1'b1, 1'b1, 10'h000, 32'h1234_5678);
    #3;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_sram_we", 32'(sram_we), 0);
    chk("rst_sram_wmask", 32'(sram_wmask), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk);
    #1;
    preload = 1'b0;
    rst = 1'b0;
    set_req(1'b0, 1'b0, 10'h000, 32'h0);
    #1;
    chk("post_rst_ready", 32'(req_ready), 1);

    // Streaming: 16 back-to-back reads, responses on consecutive cycles.
    for (int i = 0; i < 16; i++) begin
      set_req(1'b1, 1'b0, 10'(i), 32'h0);
      chk("stream_ready", 32'(req_ready), 1);
      tick();
      chk("stream_valid", 32'(rsp_valid), 32'(i >= 1));
      if (i >= 1) chk("stream_data", rsp_rdata, 32'((i - 1) * 3));
    end
    set_req(1'b0, 1'b0, 10'h000, 32'h0);
    tick();
    chk("stream_last", rsp_rdata, 32'd45);
    tick();
    chk("stream_idle", 32'(rsp_valid), 0);

    // Write then read same address.
    set_req(1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF);
    tick();
    set_req(1'b1, 1'b0, 10'h005, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 10'h000, 32'h0);
    chk("wr_rd_lat1", 32'(rsp_valid), 0);
    tick();
    chk("wr_rd_lat2", 32'(rsp_valid), 1);
    chk("wr_rd_data", rsp_rdata, 32'hDEAD_BEEF);
    tick();

    // Backpressure: exactly three reads accepted with rsp_ready low.
    rsp_ready = 1'b0;
    acc = 0;
    a = 10'h010;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 1'b0, a, 32'h0);
      tick();
      if (last_fire) begin
        acc++;
        a = a + 10'd1;
      end
    end
    chk("bp_accepted", 32'(acc), 3);
    chk("bp_ready_low", 32'(req_ready), 0);
    set_req(1'b0, 1'b0, 10'h000, 32'h0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_drain0", rsp_rdata, 32'h30);
    tick();
    chk("bp_drain1", rsp_rdata, 32'h33);
    tick();
    chk("bp_drain2", rsp_rdata, 32'h36);
    tick();
    chk("bp_empty", 32'(rsp_valid), 0);
    chk("bp_resume", 32'(req_ready), 1);

    // Alternating write 0x3FF / read 0x000: only reads respond, never X.
    nresp = 0;
    for (int i = 0; i < 11; i++) begin
      if (i >= 8) set_req(1'b0, 1'b0, 10'h000, 32'h0);
      else if (i % 2 == 0) set_req(1'b1, 1'b1, 10'h3FF, 32'hA5A5_0000 | 32'(i));
      else set_req(1'b1, 1'b0, 10'h000, 32'h0);
      tick();
      if (rsp_valid) chk("mixed_noX", 32'($isunknown(rsp_rdata)), 0);
      if (last_pop) nresp++;
    end
    chk("mixed_nresp", 32'(nresp), 4);

    // Reset with one read in flight and two responses queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b0, 10'(32 + i), 32'h0);
      tick();
    end
    chk("mr_full_ready", 32'(req_ready), 0);
    chk("mr_full_valid", 32'(rsp_valid), 1);
    set_req(1'b1, 1'b1, 10'h001, 32'h0BAD_0BAD);
    rst = 1'b1;
    #1;
    chk("mr_rsp_valid", 32'(rsp_valid), 0);
    chk("mr_req_ready", 32'(req_ready), 0);
    chk("mr_sram_we", 32'(sram_we), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(1'b0, 1'b0, 10'h000, 32'h0);
    rsp_ready = 1'b1;
    #1;
    chk("mr_release_ready", 32'(req_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_stale", 32'(rsp_valid), 0);
    end

    // Random traffic against the scoreboard.
    ops = 0;
    cyc = 0;
    while (ops < 2000 && cyc < 20000) begin
      r = int'($urandom_range(0, 3));
      a = (r == 0) ? 10'h000 : (r == 1) ? 10'h3FF : 10'($urandom);
      set_req(($urandom_range(0, 3) != 0), 1'($urandom), a, $urandom);
      req_wmask = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_fire) ops++;
      cyc++;
    end
    chk("rand_ops", 32'(ops), 2000);

    // Explicit boundary round-trips.
    set_req(1'b1, 1'b1, 10'h000, 32'h0000_0A0A);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    set_req(1'b1, 1'b1, 10'h3FF, 32'hF0F0_3FF0);
    tick();
    set_req(1'b1, 1'b0, 10'h000, 32'h0);
    tick();
    set_req(1'b1, 1'b0, 10'h3FF, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 10'h000, 32'h0);
    chk("bnd_lo", rsp_rdata, 32'h0000_0A0A);
    tick();
    chk("bnd_hi", rsp_rdata, 32'hF0F0_3FF0);
    for (int i = 0; i < 3; i++) tick();
    chk("final_empty", 32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
